ex_muldiv_unit: RTL
===================

// Module: ex_muldiv_unit
// PURPOSE
//  Multi-cycle RV32M multiply/divide engine in the EX stage. Consumes the operands and funct3
//  held in the ID/EX pipeline register and back-pressures it with stall until the result is
//  ready. Then it presents a one-cycle done/result to the EX/MEM path.
//  Uses an iterative radix-2 restoring divider; multiply is single-cycle or iterative (see CONFIGURATION).
// PARAMETERS
//  XLEN   32  operand/result width; only 32 is supported
//  CNT_W  5   iteration counter width, $clog2(XLEN)
// PORTS
//  clock     in   1     sole clock; all state updates on posedge
//  reset     in   1     asynchronous, active-high; forces IDLE and clears all outputs
//  start     in   1     ID/EX output holds a valid M-extension op (funct7==0000001, opcode OP)
//  op        in   3     funct3: MUL=0 MULH=1 MULHSU=2 MULHU=3 DIV=4 DIVU=5 REM=6 REMU=7
//  rs1_data  in   XLEN  operand a
//  rs2_data  in   XLEN  operand b
//  flush     in   1     synchronous abort (branch redirect); kills the op in flight
//  stall     out  1     combinational; =start & ~done; holds PC, IF/ID and ID/EX
//  done      out  1     registered; 1-cycle pulse, result valid
//  result    out  XLEN  registered; meaningful only while done=1, holds its value otherwise
// BEHAVIOUR
//  Reset: state=IDLE; done=0; result=0; counter=0; internal accumulators=0. Reset may assert in any state.
//  States: IDLE, MUL_ITER, DIV_ITER, DONE (muldiv_state_e).
//  - IDLE: if start & ~flush, latch op, |a|, |b| and sign flags, then branch:
//      DIV/REM with b==0        -> DONE; quotient=all ones, remainder=a
//      DIV/REM with a=0x80000000, b=-1 (signed only) -> DONE; quotient=0x80000000, remainder=0
//      MUL* -> MUL_ITER, or DONE with product when the fast-multiply option is enabled
//      other DIV/REM            -> DIV_ITER with counter=31
//  - MUL_ITER / DIV_ITER: one shift-add or restoring-subtract step per cycle; counter decrements.
//      At counter==0: apply sign fix-up, register result, go to DONE.
//  - DONE: done=1 for exactly this cycle. Then go unconditionally to IDLE; start is not sampled in DONE.
//  Signs:
//      MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU/DIVU/REMU: unsigned.
//      Quotient negative iff signs differ. Remainder takes the sign of a.
//  Result select: MUL = product[31:0]; MULH* = product[63:32]; DIV* = quotient; REM* = remainder.
//  Latency (accept edge = cycle 0):
//      iterative op: done in cycle 33, stall high in cycles 0..32
//      special-case divide: done in cycle 1
//  flush: in any state, next state=IDLE, done=0, result held. flush with start in IDLE: no accept.
//  start dropping mid-iteration without flush is illegal. Assertion: start stays high while state!=IDLE.
//  Back-to-back ops: 1 IDLE cycle between DONE and the next accept.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined: MUL* computes the full 64-bit product in the IDLE accept cycle.
//    Goes directly to DONE; done in cycle 1. MUL_ITER is unreachable and is not synthesized.
//  MULDIV_FAST_MUL_EN undefined: 32-step shift-add in MUL_ITER; done in cycle 33. No DSP inference.
//  Divide behaviour is identical in both builds.
// STRUCTURE
//  cpu_pkg gets:
//    muldiv_op_e (funct3 encodings above)
//    muldiv_state_e
//    localparams MULDIV_FUNCT7=7'b0000001, DIV_BY_ZERO_Q='1
//  Sub-module muldiv_signfix is combinational: operand magnitude/sign extraction and final
//  result negation, instantiated once. Iteration datapath and FSM stay in ex_muldiv_unit.
// TESTING
//  1 DIV  a=-20 (0xFFFFFFEC), b=3 -> done in cycle 33, result=0xFFFFFFFA (-6); REM same -> 0xFFFFFFFE (-2)
//  2 DIVU a=7, b=0 -> done in cycle 1, result=0xFFFFFFFF; REMU a=7, b=0 -> result=7
//  3 DIV  a=0x80000000, b=0xFFFFFFFF -> result=0x80000000; REM -> 0; stall high only in cycle 0
//  4 MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000000
//    MULHU same operands -> 0xFFFFFFFE
//    MULHSU same operands -> 0xFFFFFFFF
//    MUL a=0x12345678, b=0x10 -> 0x23456780
//    latency: 1 with MULDIV_FAST_MUL_EN, 33 without
//  5 flush in cycle 10 of DIVU: IDLE next cycle, no done pulse, stall drops
//    a new start immediately after the flush is accepted and gives the correct result
//  6 reset asserted async in cycle 15 of DIV (between clock edges): state=IDLE, done=0, result=0 before next edge

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types for the EX-stage multiply/divide engine.
package cpu_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_ITER = 2'd1,
        DIV_ITER = 2'd2,
        DONE     = 2'd3
    } muldiv_state_e;

    localparam logic [6:0]  MULDIV_FUNCT7  = 7'b0000001;
    localparam logic [31:0] DIV_BY_ZERO_Q  = '1;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX -> mul/div handshake: operands in, stall/done/result back.
interface ex_muldiv_unit_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, rs1_data, rs2_data, flush,
                    input  stall, done, result);
    modport slave  (input  start, op, rs1_data, rs2_data, flush,
                    output stall, done, result);
endinterface

// File: rtl/muldiv_signfix.sv
// Combinational operand magnitude/sign extraction and final result sign fix-up.
module muldiv_signfix
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  muldiv_op_e        op_in,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   a_mag,
    output logic [XLEN-1:0]   b_mag,
    output logic              neg_p,
    output logic              neg_r,
    input  muldiv_op_e        fix_op,
    input  logic              fix_neg_p,
    input  logic              fix_neg_r,
    input  logic [2*XLEN-1:0] prod,
    input  logic [XLEN-1:0]   quo,
    input  logic [XLEN-1:0]   rem,
    output logic [XLEN-1:0]   result
);
    logic              sa, sb;
    logic [2*XLEN-1:0] prod_f;
    logic [XLEN-1:0]   quo_f, rem_f;

    // MUL low word is sign-agnostic, so it runs on raw (unsigned) operands
    assign sa    = (op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) & a[XLEN-1];
    assign sb    = (op_in inside {MD_MULH, MD_DIV, MD_REM}) & b[XLEN-1];
    assign a_mag = sa ? -a : a;
    assign b_mag = sb ? -b : b;
    assign neg_p = sa ^ sb;
    assign neg_r = sa;

    assign prod_f = fix_neg_p ? -prod : prod;
    assign quo_f  = fix_neg_p ? -quo  : quo;
    assign rem_f  = fix_neg_r ? -rem  : rem;

    always_comb begin
        result = prod_f[XLEN-1:0];
        case (fix_op)
            MD_MUL:                       result = prod_f[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod_f[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              result = quo_f;
            MD_REM, MD_REMU:              result = rem_f;
            default:                      result = prod_f[XLEN-1:0];
        endcase
    end
endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide engine (radix-2 restoring divide).
// MULDIV_FAST_MUL_EN: single-cycle multiply instead of 32-step shift-add.
module ex_muldiv_unit
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic           clock,
    input  logic           reset,
    ex_muldiv_unit_if.slave bus
);
    muldiv_state_e     state;
    muldiv_op_e        op_i, op_q, fix_op;
    logic              neg_p_i, neg_r_i, neg_p_q, neg_r_q, fix_neg_p, fix_neg_r;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   hi_q, lo_q, mcand_q, a_mag, b_mag, fix_result, result_q;
    logic              done_q;
    logic [2*XLEN-1:0] fix_prod;
    logic [XLEN:0]     div_tmp, div_diff;
    logic              div_ge, div_zero, div_ovf, is_rem;
    logic [XLEN-1:0]   div_rem_n, div_quo_n;

    assign op_i      = muldiv_op_e'(bus.op);
    assign bus.stall = bus.start & ~done_q;
    assign bus.done  = done_q;
    assign bus.result = result_q;

    assign is_rem   = op_i[1];
    assign div_zero = (bus.rs2_data == '0);
    assign div_ovf  = ~op_i[0] & (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.rs2_data);

    // Divide: hi_q = partial remainder, lo_q = dividend shifting out / quotient shifting in
    assign div_tmp   = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_tmp - {1'b0, mcand_q};
    assign div_ge    = ~div_diff[XLEN];
    assign div_rem_n = div_ge ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0];
    assign div_quo_n = {lo_q[XLEN-2:0], div_ge};

`ifdef MULDIV_FAST_MUL_EN
    assign fix_prod  = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    assign fix_op    = (state == IDLE) ? op_i    : op_q;
    assign fix_neg_p = (state == IDLE) ? neg_p_i : neg_p_q;
    assign fix_neg_r = (state == IDLE) ? neg_r_i : neg_r_q;
`else
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_n, mul_lo_n;
    // Multiply: {hi_q, lo_q} shifts right, multiplier bits consumed from lo_q[0]
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_hi_n  = mul_sum[XLEN:1];
    assign mul_lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
    assign fix_prod  = {mul_hi_n, mul_lo_n};
    assign fix_op    = op_q;
    assign fix_neg_p = neg_p_q;
    assign fix_neg_r = neg_r_q;
`endif

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .op_in     (op_i),
        .a         (bus.rs1_data),
        .b         (bus.rs2_data),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .neg_p     (neg_p_i),
        .neg_r     (neg_r_i),
        .fix_op    (fix_op),
        .fix_neg_p (fix_neg_p),
        .fix_neg_r (fix_neg_r),
        .prod      (fix_prod),
        .quo       (div_quo_n),
        .rem       (div_rem_n),
        .result    (fix_result)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= MD_MUL;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            cnt      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        op_q    <= op_i;
                        neg_p_q <= neg_p_i;
                        neg_r_q <= neg_r_i;
                        cnt     <= CNT_W'(XLEN-1);
                        if (op_i[2]) begin
                            if (div_zero) begin
                                result_q <= is_rem ? bus.rs1_data : DIV_BY_ZERO_Q;
                                done_q   <= 1'b1;
                                state    <= DONE;
                            end else if (div_ovf) begin
                                result_q <= is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                                done_q   <= 1'b1;
                                state    <= DONE;
                            end else begin
                                hi_q    <= '0;
                                lo_q    <= a_mag;
                                mcand_q <= b_mag;
                                state   <= DIV_ITER;
                            end
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            result_q <= fix_result;
                            done_q   <= 1'b1;
                            state    <= DONE;
`else
                            hi_q    <= '0;
                            lo_q    <= b_mag;
                            mcand_q <= a_mag;
                            state   <= MUL_ITER;
`endif
                        end
                    end
`ifndef MULDIV_FAST_MUL_EN
                    MUL_ITER: begin
                        hi_q <= mul_hi_n;
                        lo_q <= mul_lo_n;
                        cnt  <= cnt - 1'b1;
                        if (cnt == '0) begin
                            result_q <= fix_result;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end
                    end
`endif
                    DIV_ITER: begin
                        hi_q <= div_rem_n;
                        lo_q <= div_quo_n;
                        cnt  <= cnt - 1'b1;
                        if (cnt == '0) begin
                            result_q <= fix_result;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // ID/EX must hold the op until done (or a flush kills it)
    a_start_held: assert property (@(posedge clock) disable iff (reset)
        (state != IDLE && !bus.flush) |-> bus.start);

endmodule
